// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Brief    : Drains a registered-read FIFO one byte at a time and sends each
//            byte as an 8-bit asynchronous UART frame on a registered tx line
//            (start bit, LSB-first data, optional parity, 1 or 2 stop bits).
// Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int CLK_DIV   = 104,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       empty,
    input  logic [7:0] q,
    output logic       re,
    output logic       tx,
    output logic       busy
);

    localparam int                CNT_W       = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]  BAUD_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic              STOP_LAST   = 1'(STOP_BITS - 1);
    localparam bit                HAS_PARITY  = (PARITY != 0);
    localparam bit                EVEN_PARITY = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_PARITY = 3'd5,
        S_STOP   = 3'd6
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   baud,  baud_nxt;
    logic [2:0]         bitn,  bitn_nxt;
    logic [7:0]         shift, shift_nxt;
    logic               par,   par_nxt;
    logic               stopn, stopn_nxt;
    logic               tx_nxt;
    logic               bit_end;

    // The bit period ends on the last count; the counter wraps to 0 there.
    assign bit_end = (baud == BAUD_LAST);

    // The FIFO read strobe and busy flag are pure functions of the state.
    assign re   = (state == S_FETCH);
    assign busy = (state != S_IDLE);

    // Next-state and datapath: tx_nxt is the line level for the next cycle,
    // so the tx register always holds the value belonging to the current state.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud;
        bitn_nxt  = bitn;
        shift_nxt = shift;
        par_nxt   = par;
        stopn_nxt = stopn;
        tx_nxt    = 1'b1;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                state_nxt = S_LOAD;
            end
            S_LOAD: begin
                shift_nxt = q;
                par_nxt   = 1'b0;
                baud_nxt  = '0;
                bitn_nxt  = 3'd0;
                stopn_nxt = 1'b0;
                state_nxt = S_START;
                tx_nxt    = 1'b0;
            end
            S_START: begin
                tx_nxt = 1'b0;
                if (bit_end) begin
                    baud_nxt  = '0;
                    state_nxt = S_DATA;
                    tx_nxt    = shift[0];
                end else begin
                    baud_nxt = baud + CNT_W'(1);
                end
            end
            S_DATA: begin
                tx_nxt = shift[0];
                if (bit_end) begin
                    baud_nxt  = '0;
                    par_nxt   = par ^ shift[0];
                    shift_nxt = {1'b0, shift[7:1]};
                    bitn_nxt  = bitn + 3'd1;
                    if (bitn == 3'd7) begin
                        if (HAS_PARITY) begin
                            state_nxt = S_PARITY;
                            tx_nxt    = EVEN_PARITY ? par_nxt : ~par_nxt;
                        end else begin
                            state_nxt = S_STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        tx_nxt = shift[1];
                    end
                end else begin
                    baud_nxt = baud + CNT_W'(1);
                end
            end
            S_PARITY: begin
                tx_nxt = tx;
                if (bit_end) begin
                    baud_nxt  = '0;
                    state_nxt = S_STOP;
                    tx_nxt    = 1'b1;
                end else begin
                    baud_nxt = baud + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_nxt = '0;
                    if (stopn == STOP_LAST) begin
                        state_nxt = S_IDLE;
                    end else begin
                        stopn_nxt = 1'b1;
                    end
                end else begin
                    baud_nxt = baud + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            baud  <= '0;
            bitn  <= 3'd0;
            shift <= 8'd0;
            par   <= 1'b0;
            stopn <= 1'b0;
            tx    <= 1'b1;
        end else begin
            state <= state_nxt;
            baud  <= baud_nxt;
            bitn  <= bitn_nxt;
            shift <= shift_nxt;
            par   <= par_nxt;
            stopn <= stopn_nxt;
            tx    <= tx_nxt;
        end
    end

endmodule
`default_nettype wire

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmitter that sits directly downstream of the block-RAM FIFO and drains it. Whenever the FIFO reports non-empty, the block pops one byte and sends it on a single TX line as an asynchronous 8-bit UART frame: LSB first, optional parity, configurable stop bits. It uses one clock domain: the FIFO read clock is the same `clk`. It is the standard outbound path from the FIFO to an off-chip UART pin.

## Interface
- `CLK_DIV`, default 104: `clk` cycles per bit period. Legal range 2..65535.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: stop-bit count. Legal values 1 or 2.

- `clk`  in  1: single clock. Also drives the FIFO `r_clk`.
- `rst`  in  1: asynchronous, active-high reset.
- `empty`  in  1: FIFO empty flag.
- `q`  in  8: FIFO read data. Valid on the cycle after `re` was sampled high (registered BRAM read).
- `re`  out  1: FIFO read strobe. One-cycle pulse per byte.
- `tx`  out  1: serial line. Idles high.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- State machine: IDLE → FETCH → LOAD → START → DATA → [PARITY] → STOP → IDLE.
- **IDLE:** `tx`=1. If `empty`=0 at a clock edge, go to FETCH. Otherwise stay.
- **FETCH:** `re`=1 for exactly this one cycle (Moore output, `re` = state==FETCH). Go to LOAD unconditionally.
- **LOAD:** capture `q` into the 8-bit shift register. Clear the parity accumulator and the baud counter. Go to START.
- **START:** `tx`=0 for `CLK_DIV` cycles.
- **DATA:**
  - `tx` = shift[0] for `CLK_DIV` cycles per bit.
  - Shift right at the end of each bit period.
  - A 3-bit counter counts bits 0..7. Leave DATA after bit 7.
  - Accumulate XOR of the transmitted bits.
- **PARITY** (only when `PARITY`≠0): `tx` = xor for even parity, ~xor for odd parity. Duration `CLK_DIV` cycles.
- **STOP:** `tx`=1 for `STOP_BITS`×`CLK_DIV` cycles, then go to IDLE.
- **Baud counter:** width `$clog2(CLK_DIV)`. Counts 0..`CLK_DIV`-1. The bit period ends on the cycle the count equals `CLK_DIV`-1; the counter then wraps to 0. It never counts past `CLK_DIV`-1.
- **`empty` sampling:** `empty` is sampled only in IDLE. Changes to `empty` during a frame have no effect.
- **Reads per frame:** exactly one `re` pulse per frame. The block never pops while `empty`=1.
- **`tx` glitch-free:** `tx` is driven from a register, never combinationally.
- **Reset:** `rst` asserted at any time, including mid-frame, forces the following immediately and asynchronously:
  - state = IDLE, `tx`=1, `re`=0, `busy`=0.
  - All counters and the shift register = 0.
  - A partially sent byte is discarded, not retried.
  - The first possible `re` is one cycle after `rst` deasserts with `empty`=0.

## Timing
- **Reset values:** `tx`=1, `re`=0, `busy`=0.
- **`empty` to `re`:** `empty` falls in IDLE → `re` high on the next cycle (FETCH).
- **`re` to start bit:** `tx` falls 2 cycles after the `re` cycle (LOAD, then START).
- **Frame length in cycles:** (1 + 8 + (`PARITY`≠0) + `STOP_BITS`) × `CLK_DIV`.
- **Back-to-back bytes:**
  - End of STOP → IDLE → FETCH → LOAD → START.
  - The line is high for `STOP_BITS`×`CLK_DIV` + 3 cycles between frames.
  - Byte-to-byte period = frame length + 3 cycles.
- **`busy` timing:** rises in the cycle FETCH is entered and falls in the cycle IDLE is re-entered.

## Test plan
- **Reset state:** `CLK_DIV`=4, `PARITY`=0, `STOP_BITS`=1. Hold `rst`=1, `empty`=0 → `tx`=1, `re`=0, `busy`=0 throughout.
- **Single byte:** same config. Release `rst`; `empty`=0 for one byte, `q`=0xA5 on the cycle after `re`, then `empty`=1.
  - Exactly one `re` pulse.
  - `tx`, in 4-cycle bits: 0, 1,0,1,0,0,1,0,1, 1.
  - `busy` high for 2 + 40 cycles.
- **Back-to-back bytes:** FIFO holds 0x00 then 0xFF.
  - Two `re` pulses 43 cycles apart.
  - Start bit of the second frame begins 3 cycles after the first stop bit ends.
  - No third `re`.
- **Parity and two stop bits:** `PARITY`=1 (odd), `STOP_BITS`=2, `q`=0x07.
  - Parity bit = 0 (three ones, odd parity).
  - Stop high for 8 cycles.
  - Frame is 48 cycles.
  - Repeat with `PARITY`=2 → parity bit = 1.
- **Reset mid-frame:** pulse `rst` during data bit 3.
  - `tx`=1 in the same cycle, asynchronously.
  - `busy`=0.
  - After release with `empty`=0, a fresh `re` occurs 1 cycle later and a full frame follows.
- **`empty` ignored during a frame:** toggle `empty` every cycle mid-frame → no `re` until IDLE is re-entered.
